// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// Used by mc_decode and multicycle_ctrl.
package mc_pkg;

  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_SHIFT,
    CLS_JR,
    CLS_JALR,
    CLS_J,
    CLS_JAL,
    CLS_BEQ,
    CLS_LW,
    CLS_SW,
    CLS_IALU,
    CLS_LUI,
    CLS_ILLEGAL
  } cls_t;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MDR = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BR   = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/mc_decode.sv
// OpCode/Funct to instruction class for the multi-cycle control FSM.
// Anything not in the supported set maps to CLS_ILLEGAL.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls
);

  // R-type split by funct, everything else by opcode
  always_comb begin
    cls = CLS_ILLEGAL;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          F_SLL, F_SRL, F_SRA: cls = CLS_SHIFT;
          F_JR:                cls = CLS_JR;
          F_JALR:              cls = CLS_JALR;
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:       cls = CLS_RTYPE;
          default:             cls = CLS_ILLEGAL;
        endcase
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      OP_BEQ:  cls = CLS_BEQ;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI: cls = CLS_IALU;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core (IF/ID/EX/MEM/WB/TRAP).
// Option: MC_CTRL_MEM_WAIT_EN adds mem_ready wait states in IF and MEM.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [2:0] state_o
);

  state_t state_q;
  state_t state_d;
  cls_t   cls;
  ctl_t   c;
  ctl_t   o;
  logic   rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  mc_decode u_dec (
    .op    (OpCode),
    .funct (Funct),
    .cls   (cls)
  );

  // state register; reset aborts any instruction back to IF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // next state and control decode from state and class
  always_comb begin
    c       = '0;
    state_d = state_q;
    unique case (state_q)
      S_IF: begin
        c.memread = 1'b1;
        c.irwrite = rdy;
        c.pcwrite = rdy;
        c.alusrca = SRCA_PC;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        if (rdy) state_d = S_ID;
      end
      S_ID: begin
        c.alusrca = SRCA_PC;
        c.alusrcb = SRCB_BR;
        c.aluop   = ALUOP_ADD;
        unique case (cls)
          CLS_J: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_JUMP;
            state_d    = S_IF;
          end
          CLS_JAL: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_JUMP;
            c.regwrite = 1'b1;
            c.regdst   = REGDST_RA;
            c.memtoreg = MTR_PC;
            state_d    = S_IF;
          end
          CLS_JR: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_RS;
            state_d    = S_IF;
          end
          CLS_JALR: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_RS;
            c.regwrite = 1'b1;
            c.regdst   = REGDST_RD;
            c.memtoreg = MTR_PC;
            state_d    = S_IF;
          end
          CLS_ILLEGAL: state_d = S_TRAP;
          default:     state_d = S_EX;
        endcase
      end
      S_EX: begin
        unique case (cls)
          CLS_BEQ: begin
            c.alusrca     = SRCA_RS;
            c.alusrcb     = SRCB_RT;
            c.aluop       = ALUOP_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = PCSRC_ALUOUT;
            state_d       = S_IF;
          end
          CLS_LW, CLS_SW: begin
            c.alusrca = SRCA_RS;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_ADD;
            state_d   = S_MEM;
          end
          CLS_SHIFT: begin
            c.alusrca = SRCA_SHAMT;
            c.alusrcb = SRCB_RT;
            c.aluop   = ALUOP_FUNCT;
            state_d   = S_WB;
          end
          CLS_RTYPE: begin
            c.alusrca = SRCA_RS;
            c.alusrcb = SRCB_RT;
            c.aluop   = ALUOP_FUNCT;
            state_d   = S_WB;
          end
          CLS_IALU, CLS_LUI: begin
            c.alusrca = SRCA_RS;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_FUNCT;
            state_d   = S_WB;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        c.iord = IORD_ALU;
        if (cls == CLS_SW) begin
          c.memwrite = 1'b1;
          if (rdy) state_d = S_IF;
        end else begin
          c.memread = 1'b1;
          if (rdy) state_d = S_WB;
        end
      end
      S_WB: begin
        c.regwrite = 1'b1;
        if (cls == CLS_RTYPE || cls == CLS_SHIFT)
          c.regdst = REGDST_RD;
        if (cls == CLS_LW)
          c.memtoreg = MTR_MDR;
        state_d = S_IF;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
        state_d   = S_TRAP;
      end
      default: state_d = S_IF;
    endcase
  end

  assign o = reset ? '0 : c;

  assign PCWrite     = o.pcwrite;
  assign PCWriteCond = o.pcwritecond;
  assign IorD        = o.iord;
  assign MemRead     = o.memread;
  assign MemWrite    = o.memwrite;
  assign IRWrite     = o.irwrite;
  assign RegWrite    = o.regwrite;
  assign RegDst      = o.regdst;
  assign MemtoReg    = o.memtoreg;
  assign ALUSrcA     = o.alusrca;
  assign ALUSrcB     = o.alusrcb;
  assign PCSource    = o.pcsource;
  assign ALUOp       = o.aluop;
  assign illegal     = o.illegal;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Walks lw/srl/jal/beq/sw/jr/addi, mid-instruction reset and TRAP.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD;
  logic       MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [1:0] PCSource, ALUOp;
  logic       illegal;
  logic [2:0] state_o;
  logic [22:0] outs;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .illegal     (illegal),
    .state_o     (state_o)
  );

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead,
                 MemWrite, IRWrite, RegWrite, RegDst,
                 MemtoReg, ALUSrcA, ALUSrcB, PCSource,
                 ALUOp, illegal, state_o};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("rd_wr_excl", {31'd0, MemRead & MemWrite}, 0);
    chk("rw_wr_excl", {31'd0, RegWrite & MemWrite}, 0);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    OpCode    = 6'h00;
    Funct     = 6'h20;
    step(); step(); step();
    chk("rst_outs", {9'd0, outs}, 0);

    reset = 1'b0;
    #1;
    chk("c0_state", state_o, 0);
    chk("c0_mrd", MemRead, 1);
    chk("c0_irw", IRWrite, 1);
    chk("c0_pcw", PCWrite, 1);
    chk("c0_srcb", ALUSrcB, 1);
    chk("c0_srca", ALUSrcA, 0);
    chk("c0_aluop", ALUOp, 0);

    // lw: IF ID EX MEM WB
    OpCode = 6'h23;
    step();
    chk("lw_id", state_o, 1);
    chk("lw_id_srcb", ALUSrcB, 3);
    chk("lw_id_pcw", PCWrite, 0);
    step();
    chk("lw_ex", state_o, 2);
    chk("lw_ex_srca", ALUSrcA, 1);
    chk("lw_ex_srcb", ALUSrcB, 2);
    step();
    chk("lw_mem", state_o, 3);
    chk("lw_mem_iord", IorD, 1);
    chk("lw_mem_mrd", MemRead, 1);
    chk("lw_mem_mwr", MemWrite, 0);
    step();
    chk("lw_wb", state_o, 4);
    chk("lw_wb_rw", RegWrite, 1);
    chk("lw_wb_m2r", MemtoReg, 1);
    chk("lw_wb_dst", RegDst, 0);
    step();
    chk("lw_done", state_o, 0);

    // srl
    OpCode = 6'h00;
    Funct  = 6'h02;
    step();
    chk("srl_id", state_o, 1);
    step();
    chk("srl_ex", state_o, 2);
    chk("srl_ex_srca", ALUSrcA, 2);
    chk("srl_ex_srcb", ALUSrcB, 0);
    chk("srl_ex_aluop", ALUOp, 2);
    step();
    chk("srl_wb", state_o, 4);
    chk("srl_wb_dst", RegDst, 1);
    chk("srl_wb_rw", RegWrite, 1);
    chk("srl_wb_m2r", MemtoReg, 0);
    step();
    chk("srl_done", state_o, 0);

    // jal
    OpCode = 6'h03;
    step();
    chk("jal_id", state_o, 1);
    chk("jal_pcw", PCWrite, 1);
    chk("jal_pcsrc", PCSource, 2);
    chk("jal_rw", RegWrite, 1);
    chk("jal_dst", RegDst, 2);
    chk("jal_m2r", MemtoReg, 2);
    step();
    chk("jal_done", state_o, 0);

    // beq
    OpCode = 6'h04;
    step();
    step();
    chk("beq_ex", state_o, 2);
    chk("beq_cond", PCWriteCond, 1);
    chk("beq_pcw", PCWrite, 0);
    chk("beq_aluop", ALUOp, 1);
    chk("beq_pcsrc", PCSource, 1);
    chk("beq_srca", ALUSrcA, 1);
    chk("beq_srcb", ALUSrcB, 0);
    step();
    chk("beq_done", state_o, 0);

    // sw
    OpCode = 6'h2B;
    step();
    step();
    chk("sw_ex_srcb", ALUSrcB, 2);
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sww_state", state_o, 3);
      chk("sww_mwr", MemWrite, 1);
    end
    mem_ready = 1'b1;
    #1;
    chk("sww_state4", state_o, 3);
    chk("sww_mwr4", MemWrite, 1);
    step();
    chk("sww_done", state_o, 0);
`else
    mem_ready = 1'b0;
    step();
    chk("sw_mem", state_o, 3);
    chk("sw_mwr", MemWrite, 1);
    chk("sw_mrd", MemRead, 0);
    chk("sw_iord", IorD, 1);
    chk("sw_rw", RegWrite, 0);
    step();
    chk("sw_done", state_o, 0);
    chk("nowait_irw", IRWrite, 1);
    mem_ready = 1'b1;
`endif

    // jr
    OpCode = 6'h00;
    Funct  = 6'h08;
    step();
    chk("jr_pcw", PCWrite, 1);
    chk("jr_pcsrc", PCSource, 3);
    chk("jr_rw", RegWrite, 0);
    step();
    chk("jr_done", state_o, 0);

    // addi
    OpCode = 6'h08;
    step();
    step();
    chk("addi_ex_srca", ALUSrcA, 1);
    chk("addi_ex_srcb", ALUSrcB, 2);
    chk("addi_ex_aluop", ALUOp, 2);
    step();
    chk("addi_wb", state_o, 4);
    chk("addi_wb_dst", RegDst, 0);
    step();
    chk("addi_done", state_o, 0);

    // reset asserted in EX
    step();
    step();
    chk("rex_pre", state_o, 2);
    reset = 1'b1;
    #1;
    chk("rex_outs", {9'd0, outs}, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rex_if", state_o, 0);
    chk("rex_irw", IRWrite, 1);
    chk("rex_rw", RegWrite, 0);

    // unsupported opcode -> TRAP
    OpCode = 6'h3F;
    step();
    chk("ill_id", state_o, 1);
    chk("ill_id_flag", illegal, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("trap_state", state_o, 5);
      chk("trap_flag", illegal, 1);
      chk("trap_strb", {PCWrite, MemRead, MemWrite, RegWrite, IRWrite}, 0);
    end
    reset = 1'b1;
    #1;
    chk("trap_rst_flag", illegal, 0);
    step();
    reset = 1'b0;
    #1;
    chk("trap_rst_if", state_o, 0);
    chk("trap_rst_mrd", MemRead, 1);

    // unsupported funct -> TRAP
    OpCode = 6'h00;
    Funct  = 6'h01;
    step();
    step();
    chk("illf_state", state_o, 5);
    chk("illf_flag", illegal, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
